pc_ras_unit: RTL and testbench

- Parametrised program-counter unit for the LC-3 datapath: PC register, next-PC select, and a small hardware return-address stack (RAS).
- Next-PC sources: increment, EAB adder, bus, interrupt/trap vector, and RAS pop. Adds width, reset vector and stack depth as parameters.
- Sits between the address-generation logic (EAB), the system bus, and the fetch stage that consumes PCOut.

---
 rtl/lc3_pc_pkg.sv | 19 +
 rtl/ras_stack.sv | 61 ++++++
 rtl/pc_ras_unit.sv | 69 ++++++
 tb/tb_pc_ras_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pc_pkg.sv
// Shared definitions for the LC-3 program-counter unit: next-PC select codes,
// default reset vector and the control bundle sampled each cycle.
package lc3_pc_pkg;

  localparam logic [2:0] SEL_INC = 3'b000;
  localparam logic [2:0] SEL_EAB = 3'b001;
  localparam logic [2:0] SEL_BUS = 3'b010;
  localparam logic [2:0] SEL_VEC = 3'b011;
  localparam logic [2:0] SEL_RAS = 3'b100;

  localparam logic [15:0] RESET_VECTOR_DEF = 16'h3000;

  typedef struct packed {
    logic       ld;
    logic [2:0] sel;
    logic       push;
  } pc_ctrl_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO. When full, a push overwrites the oldest entry;
// a simultaneous push+pop on a non-empty stack replaces the top in place.
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tptr;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    tptr_inc, tptr_dec, wr_ptr;

  // Explicit wrap keeps non-power-of-two depths correct.
  assign tptr_inc = (tptr == PW'(DEPTH - 1)) ? '0 : tptr + PW'(1);
  assign tptr_dec = (tptr == '0) ? PW'(DEPTH - 1) : tptr - PW'(1);

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign top   = empty ? '0 : mem[tptr];
  assign ovf   = push && !pop && full;
  assign udf   = pop && empty;

  // Push+pop on a live stack rewrites the current top; otherwise push goes above it.
  assign wr_ptr = (pop && !empty) ? tptr : tptr_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tptr <= '0;
      cnt  <= '0;
    end else if (push && pop) begin
      if (empty) begin
        tptr <= tptr_inc;
        cnt  <= cnt + CW'(1);
      end
    end else if (push) begin
      tptr <= tptr_inc;
      if (!full) cnt <= cnt + CW'(1);
    end else if (pop && !empty) begin
      tptr <= tptr_dec;
      cnt  <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// LC-3 PC register with next-PC select and a hardware return-address stack.
// rasErr latches any RAS overflow/underflow until reset.
module pc_ras_unit
  import lc3_pc_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter logic [31:0] RESET_VECTOR = 32'(RESET_VECTOR_DEF),
  parameter int          INC          = 1,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ldPC,
  input  logic [2:0]       selPC,
  input  logic [WIDTH-1:0] eabOut,
  input  logic [WIDTH-1:0] Bus,
  input  logic [WIDTH-1:0] vecIn,
  input  logic             push,
  output logic [WIDTH-1:0] PCOut,
  output logic [WIDTH-1:0] rasTop,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasErr
);
  pc_ctrl_t         ctrl;
  logic [WIDTH-1:0] pcInc, pc_nxt;
  logic             rs_push, rs_pop, rs_ovf, rs_udf;

  assign ctrl    = '{ld: ldPC, sel: selPC, push: push};
  assign pcInc   = PCOut + WIDTH'(INC);
  assign rs_push = ctrl.ld && ctrl.push;
  assign rs_pop  = ctrl.ld && (ctrl.sel == SEL_RAS);

  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (rs_push),
    .pop   (rs_pop),
    .din   (pcInc),
    .top   (rasTop),
    .empty (rasEmpty),
    .full  (rasFull),
    .ovf   (rs_ovf),
    .udf   (rs_udf)
  );

  always_comb begin
    pc_nxt = PCOut;
    case (ctrl.sel)
      SEL_INC: pc_nxt = pcInc;
      SEL_EAB: pc_nxt = eabOut;
      SEL_BUS: pc_nxt = Bus;
      SEL_VEC: pc_nxt = vecIn;
      SEL_RAS: if (!rasEmpty) pc_nxt = rasTop;
      default: pc_nxt = PCOut;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCOut  <= WIDTH'(RESET_VECTOR);
      rasErr <= 1'b0;
    end else if (ctrl.ld) begin
      PCOut <= pc_nxt;
      if (rs_ovf || rs_udf) rasErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: a behavioural PC/stack model queues expected
// state per step; each result is popped and compared after the clock edge.
module tb_pc_ras_unit;
  import lc3_pc_pkg::*;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] top;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ldPC = 1'b0;
  logic [2:0]  selPC = 3'b0;
  logic [15:0] eabOut = '0, Bus = '0, vecIn = '0;
  logic        push = 1'b0;
  logic [15:0] PCOut, rasTop;
  logic        rasEmpty, rasFull, rasErr;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_pc;
  logic        m_err;

  pc_ras_unit #(.WIDTH(16), .RESET_VECTOR(32'h3000), .INC(1), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ldPC(ldPC), .selPC(selPC), .eabOut(eabOut),
    .Bus(Bus), .vecIn(vecIn), .push(push), .PCOut(PCOut), .rasTop(rasTop),
    .rasEmpty(rasEmpty), .rasFull(rasFull), .rasErr(rasErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 16'h3000;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic step(input logic ld, input logic [2:0] sel, input logic [15:0] eab,
                      input logic [15:0] bus, input logic [15:0] vec, input logic ps);
    logic [15:0] inc, np;
    logic        is_pop;
    int          n;
    exp_t        e, got;
    ldPC = ld; selPC = sel; eabOut = eab; Bus = bus; vecIn = vec; push = ps;
    inc    = m_pc + 16'd1;
    np     = m_pc;
    is_pop = (sel == SEL_RAS);
    n      = m_stk.size();
    if (ld) begin
      case (sel)
        SEL_INC: np = inc;
        SEL_EAB: np = eab;
        SEL_BUS: np = bus;
        SEL_VEC: np = vec;
        SEL_RAS: if (n > 0) np = m_stk[n-1]; else m_err = 1'b1;
        default: np = m_pc;
      endcase
      if (ps) begin
        if (is_pop && n > 0) m_stk[n-1] = inc;
        else begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            m_err = 1'b1;
          end
          m_stk.push_back(inc);
        end
      end else if (is_pop && n > 0) begin
        void'(m_stk.pop_back());
      end
      m_pc = np;
    end
    e.pc    = m_pc;
    e.top   = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 16'h0;
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == 4);
    e.err   = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_underrun: observed 0 expected 1");
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("sb_pc", PCOut, got.pc);
      chk("sb_top", rasTop, got.top);
      chk1("sb_empty", rasEmpty, got.empty);
      chk1("sb_full", rasFull, got.full);
      chk1("sb_err", rasErr, got.err);
    end
  endtask

  task automatic ld_bus(input logic [15:0] v);
    step(1'b1, SEL_BUS, 16'h0, v, 16'h0, 1'b0);
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic async_reset();
    ldPC = 1'b0; push = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", PCOut, 16'h3000);
    chk("arst_top", rasTop, 16'h0);
    chk1("arst_empty", rasEmpty, 1'b1);
    chk1("arst_full", rasFull, 1'b0);
    chk1("arst_err", rasErr, 1'b0);
    #2 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] inc_seq [3];
    logic [15:0] pop_seq [4];
    inc_seq = '{16'hFFFF, 16'h0000, 16'h0001};
    pop_seq = '{16'h7131, 16'h7121, 16'h7111, 16'h7101};
    model_reset();
    #12;
    chk("rst_pc", PCOut, 16'h3000);
    chk("rst_top", rasTop, 16'h0);
    chk1("rst_empty", rasEmpty, 1'b1);
    chk1("rst_full", rasFull, 1'b0);
    chk1("rst_err", rasErr, 1'b0);
    reset = 1'b0;

    // Mid-operation reset with a live stack entry
    ld_bus(16'h1234);
    step(1'b1, 3'b101, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("hold_push_pc", PCOut, 16'h1234);
    chk("hold_push_top", rasTop, 16'h1235);
    async_reset();

    // Increment wrap, then hold with ldPC low
    ld_bus(16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, SEL_INC, 16'h0, 16'h0, 16'h0, 1'b0);
      chk("inc_seq", PCOut, inc_seq[i]);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, SEL_BUS, 16'hAAAA, 16'h5555, 16'h0, 1'b1);
      chk("ld0_hold", PCOut, 16'h0001);
    end
    chk1("ld0_empty", rasEmpty, 1'b1);

    // Call / return
    ld_bus(16'h3005);
    step(1'b1, SEL_EAB, 16'h4000, 16'h0, 16'h0, 1'b1);
    chk("call_pc", PCOut, 16'h4000);
    chk("call_top", rasTop, 16'h3006);
    step(1'b1, SEL_RAS, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("ret_pc", PCOut, 16'h3006);
    chk1("ret_empty", rasEmpty, 1'b1);

    // Overflow: five pushes into a four-deep stack, then four pops
    ld_bus(16'h7000);
    for (int i = 0; i < 5; i++)
      step(1'b1, SEL_BUS, 16'h0, 16'h7100 + 16'(i * 16), 16'h0, 1'b1);
    chk1("ovf_full", rasFull, 1'b1);
    chk1("ovf_err", rasErr, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SEL_RAS, 16'h0, 16'h0, 16'h0, 1'b0);
      chk("ovf_pop", PCOut, pop_seq[i]);
    end
    chk1("ovf_drained", rasEmpty, 1'b1);
    async_reset();

    // Underflow from empty; error stays sticky
    ld_bus(16'h3010);
    step(1'b1, SEL_RAS, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("udf_pc", PCOut, 16'h3010);
    chk1("udf_err", rasErr, 1'b1);
    step(1'b1, SEL_INC, 16'h0, 16'h0, 16'h0, 1'b0);
    step(1'b0, SEL_INC, 16'h0, 16'h0, 16'h0, 1'b0);
    chk1("udf_sticky", rasErr, 1'b1);

    // Bus / vector sources, then pop+push
    ld_bus(16'h0200);
    chk("bus_pc", PCOut, 16'h0200);
    step(1'b1, SEL_VEC, 16'h0, 16'h0, 16'h0025, 1'b0);
    chk("vec_pc", PCOut, 16'h0025);
    ld_bus(16'h4FFF);
    step(1'b1, SEL_EAB, 16'h1234, 16'h0, 16'h0, 1'b1);
    chk("pp_setup_top", rasTop, 16'h5000);
    ld_bus(16'h6000);
    step(1'b1, SEL_RAS, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("pp_pc", PCOut, 16'h5000);
    chk("pp_top", rasTop, 16'h6001);
    chk1("pp_not_empty", rasEmpty, 1'b0);
    step(1'b1, SEL_RAS, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("pp_pop_pc", PCOut, 16'h6001);
    chk1("pp_occ_one", rasEmpty, 1'b1);
    // Pop+push on an empty stack: PC holds, push still lands
    step(1'b1, SEL_RAS, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("ppe_pc", PCOut, 16'h6001);
    chk("ppe_top", rasTop, 16'h6002);

    chk("sb_drain", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
